// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fnd_pkg
// Purpose  : Segment encodings, idle drive levels and scan FSM state codes
//            shared by the FND scan controller and the keypad echo logic.
// Revision : 1.0 - initial release
// ============================================================================
package fnd_pkg;

    // Active-high segment patterns, bit order g..a
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    localparam logic [7:0] SEG_OFF = 8'h00;
    // Sized for the widest supported bank; users slice the low NUM_DIGITS bits
    localparam logic [7:0] COM_OFF = 8'hFF;

    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

endpackage : fnd_pkg
`default_nettype wire

// File: rtl/fnd_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : fnd_hex_decoder
// Purpose  : Combinational 4-bit hex nibble to 7-segment (g..a) decoder.
// Revision : 1.0 - initial release
// ============================================================================
module fnd_hex_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg7
);

    always_comb begin
        seg7 = SEG_HEX_0;
        case (hex)
            4'h0: seg7 = SEG_HEX_0;
            4'h1: seg7 = SEG_HEX_1;
            4'h2: seg7 = SEG_HEX_2;
            4'h3: seg7 = SEG_HEX_3;
            4'h4: seg7 = SEG_HEX_4;
            4'h5: seg7 = SEG_HEX_5;
            4'h6: seg7 = SEG_HEX_6;
            4'h7: seg7 = SEG_HEX_7;
            4'h8: seg7 = SEG_HEX_8;
            4'h9: seg7 = SEG_HEX_9;
            4'hA: seg7 = SEG_HEX_A;
            4'hB: seg7 = SEG_HEX_B;
            4'hC: seg7 = SEG_HEX_C;
            4'hD: seg7 = SEG_HEX_D;
            4'hE: seg7 = SEG_HEX_E;
            4'hF: seg7 = SEG_HEX_F;
        endcase
    end

endmodule : fnd_hex_decoder
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_ctrl
// Purpose  : Time-multiplexed 7-segment scan controller with blanking gap
//            and frame-aligned double-buffered display data.
// Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int TICK_DIV     = 131072,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                          clock_50m,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic                          load_en,
    output logic [7:0]                    seg,
    output logic [NUM_DIGITS-1:0]         com,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int c_IDX_W  = $clog2(NUM_DIGITS);
    localparam int c_PH_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int c_PH_W   = $clog2(c_PH_MAX);
    localparam bit c_HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [c_PH_W-1:0]     c_TICK_LAST  = c_PH_W'(TICK_DIV - 1);
    localparam logic [c_PH_W-1:0]     c_BLANK_LAST = c_PH_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_PH_W-1:0]     c_PH_ONE     = c_PH_W'(1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [NUM_DIGITS-1:0] c_COM_IDLE   = COM_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] c_COM_ONE    = NUM_DIGITS'(1);

    logic [0:0]         r_state, w_state_nxt;
    logic [c_PH_W-1:0]  r_phase, w_phase_nxt;
    logic [c_IDX_W-1:0] r_idx,   w_idx_nxt;
    logic               w_slot_end;
    logic               w_frame_end;

    logic [4*NUM_DIGITS-1:0] r_act_dig,   r_pend_dig;
    logic [NUM_DIGITS-1:0]   r_act_dp,    r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank, r_pend_blank;
    logic                    r_pend_valid;

    logic [3:0]            w_act_nib [NUM_DIGITS];
    logic [6:0]            w_seg7;
    logic                  w_lit;
    logic [7:0]            w_seg_nxt, r_seg;
    logic [NUM_DIGITS-1:0] w_com_nxt, r_com;

    // ------------------------------------------------------------------
    // Scan FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_50m) begin
        if (rst) begin
            r_state <= ST_SHOW;
            r_phase <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next state; with no blanking a slot ends on the SHOW tick
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + c_PH_ONE;
        w_idx_nxt   = r_idx;
        w_slot_end  = 1'b0;
        case (r_state)
            ST_SHOW: begin
                if (r_phase == c_TICK_LAST) begin
                    w_phase_nxt = '0;
                    if (c_HAS_BLANK) w_state_nxt = ST_BLANK;
                    else             w_slot_end  = 1'b1;
                end
            end
            ST_BLANK: begin
                if (r_phase == c_BLANK_LAST) begin
                    w_phase_nxt = '0;
                    w_state_nxt = ST_SHOW;
                    w_slot_end  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_SHOW;
                w_phase_nxt = '0;
            end
        endcase
        if (w_slot_end) w_idx_nxt = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
        w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);
    end

    // ------------------------------------------------------------------
    // Display buffers: active only changes on the frame-boundary cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clock_50m) begin
        if (rst) begin
            r_act_dig    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_pend_dig   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_pend_valid <= 1'b0;
        end else if (load_en && w_frame_end) begin
            r_act_dig    <= digits_in;
            r_act_dp     <= dp_in;
            r_act_blank  <= blank_in;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_frame_end && r_pend_valid) begin
                r_act_dig    <= r_pend_dig;
                r_act_dp     <= r_pend_dp;
                r_act_blank  <= r_pend_blank;
                r_pend_valid <= 1'b0;
            end
            if (load_en) begin
                r_pend_dig   <= digits_in;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign w_act_nib[gi] = r_act_dig[gi*4 +: 4];
        end
    endgenerate

    fnd_hex_decoder u_hex_decoder (
        .hex  (w_act_nib[r_idx]),
        .seg7 (w_seg7)
    );

    // ------------------------------------------------------------------
    // Scan FSM: output decode, registered below for glitch-free pins
    // ------------------------------------------------------------------
    always_comb begin
        w_lit     = (r_state == ST_SHOW) && !r_act_blank[r_idx];
        w_com_nxt = c_COM_IDLE;
        w_seg_nxt = SEG_OFF;
        if (w_lit) begin
            w_com_nxt = ~(c_COM_ONE << r_idx);
            w_seg_nxt = {r_act_dp[r_idx], w_seg7};
        end
    end

    always_ff @(posedge clock_50m) begin
        if (rst) begin
            r_seg <= SEG_OFF;
            r_com <= c_COM_IDLE;
        end else begin
            r_seg <= w_seg_nxt;
            r_com <= w_com_nxt;
        end
    end

    assign seg        = r_seg;
    assign com        = r_com;
    assign digit_idx  = r_idx;
    assign frame_done = w_frame_end;

endmodule : fnd_scan_ctrl
`default_nettype wire
